// File: rtl/pong_pkg.sv
// pong_pkg -- shared definitions for the pong match controller.
//   state_e          : FSM state encoding (also driven on state_dbg)
//   DEF_WIN_SCORE    : default points needed to win a match
//   DEF_SERVE_DELAY  : default VGA_CLK cycles from serve request to serve pulse
//   cnt_width()      : width of the serve-delay counter for a given delay
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSE      = 3'd3,
    ST_OVER       = 3'd4
  } state_e;

  localparam int DEF_WIN_SCORE   = 5;
  localparam int DEF_SERVE_DELAY = 25000000;

  // Counter must hold 0..delay-1; never narrower than one bit.
  function automatic int cnt_width(input int delay);
    return (delay <= 2) ? 1 : $clog2(delay);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_key_edge.sv
// key_edge -- two-flop synchronizer plus falling-edge detector for an
// active-low push button that is asynchronous to VGA_CLK.
//   VGA_CLK  in  clock, rising edge
//   reset    in  asynchronous, active-high; flops reset to 1 (released)
//   i_key_n  in  raw active-low button
//   o_press  out one-cycle pulse per 1->0 transition of the synchronized key
// o_press is combinational from r_prev/r_sync2, so a press reaches the
// consuming FSM on the third rising edge after the button falls.
module key_edge (
  input  logic VGA_CLK,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl -- match-level control for a two-player pong game.
//   VGA_CLK        in   pixel/system clock, rising edge
//   reset          in   asynchronous, active-high
//   start_n        in   start/pause/restart button, active-low, asynchronous
//   point_p1/p2    in   one-cycle pulses: player 1 / player 2 scored
//   running        out  ball/paddle datapath may move (state PLAY)
//   serve          out  one-cycle pulse: datapath recentres the ball
//   serve_dir      out  0 = launch toward player 1, 1 = toward player 2
//   score_p1/p2    out  binary scores 0..WIN_SCORE
//   game_over      out  high in state OVER
//   winner         out  0 = player 1, 1 = player 2 (valid while game_over)
//   state_dbg      out  current FSM state encoding
// There are no valid/ready handshakes here: point_* and the button press are
// single-cycle events that are consumed in the cycle they arrive or dropped.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       start_n,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       running,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_dbg
);

  localparam int            CW       = cnt_width(SERVE_DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  logic          w_press;

  state_e        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic [3:0]    r_score_p1,  w_score_p1_nxt;
  logic [3:0]    r_score_p2,  w_score_p2_nxt;
  logic          r_serve_dir, w_serve_dir_nxt;
  logic          r_winner,    w_winner_nxt;
  logic          r_serve,     w_serve_nxt;
  logic          r_running;
  logic          r_game_over;

  logic [3:0]    w_p1_inc;
  logic [3:0]    w_p2_inc;

  key_edge u_start_key (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .i_key_n (start_n),
    .o_press (w_press)
  );

  assign w_p1_inc = r_score_p1 + 4'd1;
  assign w_p2_inc = r_score_p2 + 4'd1;

  // Next-state logic. Priority in PLAY: point_p1, then point_p2, then press.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score_p1_nxt  = r_score_p1;
    w_score_p2_nxt  = r_score_p2;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;

    case (r_state)
      ST_IDLE: begin
        w_score_p1_nxt = 4'd0;
        w_score_p2_nxt = 4'd0;
        if (w_press) begin
          w_state_nxt     = ST_SERVE_WAIT;
          w_serve_dir_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end
      end

      ST_SERVE_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PLAY;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_PLAY: begin
        if (point_p1) begin
          w_score_p1_nxt = w_p1_inc;
          if (w_p1_inc == WIN) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_SERVE_WAIT;
            w_serve_dir_nxt = 1'b1;
            w_cnt_nxt       = '0;
          end
        end else if (point_p2) begin
          w_score_p2_nxt = w_p2_inc;
          if (w_p2_inc == WIN) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_SERVE_WAIT;
            w_serve_dir_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end
        end else if (w_press) begin
          w_state_nxt = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (w_press) begin
          w_state_nxt = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (w_press) begin
          w_state_nxt    = ST_IDLE;
          w_score_p1_nxt = 4'd0;
          w_score_p2_nxt = 4'd0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // serve is registered from the next-state view so it is high exactly
  // during the SERVE_WAIT cycle whose count is SERVE_DELAY-1.
  assign w_serve_nxt = (w_state_nxt == ST_SERVE_WAIT) && (w_cnt_nxt == CNT_LAST);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_score_p1  <= 4'd0;
      r_score_p2  <= 4'd0;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
      r_serve     <= 1'b0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_score_p1  <= w_score_p1_nxt;
      r_score_p2  <= w_score_p2_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_winner    <= w_winner_nxt;
      r_serve     <= w_serve_nxt;
      // Registered copies that always equal a decode of r_state.
      r_running   <= (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  assign running   = r_running;
  assign serve     = r_serve;
  assign serve_dir = r_serve_dir;
  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign state_dbg = r_state;

endmodule
